// File: rtl/prio_enc_arb.sv
// prio_enc_arb: registered N-to-log2(N) request encoder, fixed or round-robin.
// Ports: clk, rst_n, en, req[N], out_ready -> out_valid, out_idx[W], out_onehot[N], out_multi.
module prio_enc_arb #(
  parameter int N    = 8,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [$clog2(N)-1:0] out_idx,
  output logic [N-1:0]         out_onehot,
  output logic                 out_multi
);

  localparam int W = $clog2(N);

  logic [W-1:0] ptr;
  logic [W-1:0] g;
  logic [N-1:0] g_oh;
  logic         multi;
  logic         load;

  assign load  = en & (|req) & (~out_valid | out_ready);

  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi = |(req & (req - N'(1)));

  // Search order starts at ptr and wraps at N, so indices >= N never
  // appear even when N is not a power of two.
  always_comb begin
    logic found;
    int   idx;
    g     = '0;
    found = 1'b0;
    idx   = 0;
    if (MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) g = W'(i);
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = int'(ptr) + k;
        if (idx >= N) idx = idx - N;
        if (!found && req[idx]) begin
          g     = W'(idx);
          found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    g_oh    = '0;
    g_oh[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      out_multi  <= 1'b0;
      ptr        <= '0;
    end else begin
      if (load) begin
        out_valid  <= 1'b1;
        out_idx    <= g;
        out_onehot <= g_oh;
        out_multi  <= multi;
        if (MODE != 0) begin
          ptr <= (g == W'(N - 1)) ? '0 : g + W'(1);
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_arb.sv
// tb_prio_enc_arb: scoreboard bench for three prio_enc_arb configurations
// (N=4 fixed, N=4 round-robin, N=5 round-robin) sharing one stimulus.
module tb_prio_enc_arb;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic       rdy   = 1'b0;
  logic [4:0] req   = '0;

  always #5 clk = ~clk;

  logic       ov0, ov1, ov2;
  logic [1:0] oi0, oi1;
  logic [2:0] oi2;
  logic [3:0] oo0, oo1;
  logic [4:0] oo2;
  logic       om0, om1, om2;

  prio_enc_arb #(.N(4), .MODE(0)) u_fix4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[3:0]),
    .out_ready(rdy), .out_valid(ov0), .out_idx(oi0),
    .out_onehot(oo0), .out_multi(om0)
  );

  prio_enc_arb #(.N(4), .MODE(1)) u_rr4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req[3:0]),
    .out_ready(rdy), .out_valid(ov1), .out_idx(oi1),
    .out_onehot(oo1), .out_multi(om1)
  );

  prio_enc_arb #(.N(5), .MODE(1)) u_rr5 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .out_ready(rdy), .out_valid(ov2), .out_idx(oi2),
    .out_onehot(oo2), .out_multi(om2)
  );

  logic       ov [3];
  logic [2:0] oi [3];
  logic [4:0] oo [3];
  logic       om [3];

  always_comb begin
    ov[0] = ov0; oi[0] = {1'b0, oi0}; oo[0] = {1'b0, oo0}; om[0] = om0;
    ov[1] = ov1; oi[1] = {1'b0, oi1}; oo[1] = {1'b0, oo1}; om[1] = om1;
    ov[2] = ov2; oi[2] = oi2;         oo[2] = oo2;         om[2] = om2;
  end

  typedef struct packed {
    logic [2:0] idx;
    logic [4:0] oh;
    logic       m;
  } exp_t;

  exp_t q [3][$];
  int   mptr   [3] = '{0, 0, 0};
  bit   mvalid [3] = '{0, 0, 0};
  bit   fresh  [3] = '{1, 1, 1};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 2) ? 5 : 4;
  endfunction

  function automatic int mode_of(input int d);
    return (d == 0) ? 0 : 1;
  endfunction

  // Reference model: decides from the handshake rules whether a capture
  // happens and what it grants, then queues the expected output.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 3; d++) begin
        mvalid[d] = 0;
        mptr[d]   = 0;
        fresh[d]  = 1;
        q[d].delete();
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        int         n;
        int         g;
        int         i;
        logic [4:0] r;
        bit         ld;
        exp_t       e;
        n  = n_of(d);
        r  = req & 5'((1 << n) - 1);
        ld = en && (r != 0) && (!mvalid[d] || rdy);
        if (ld) begin
          g = -1;
          if (mode_of(d) == 0) begin
            for (int b = 0; b < n; b++) if (r[b]) g = b;
          end else begin
            for (int k = 0; k < n; k++) begin
              i = (mptr[d] + k) % n;
              if (g < 0 && r[i]) g = i;
            end
            mptr[d] = (g + 1) % n;
          end
          e.idx = 3'(g);
          e.oh  = 5'(1 << g);
          e.m   = ($countones(r) > 1);
          q[d].push_back(e);
          mvalid[d] = 1;
          fresh[d]  = 0;
        end else if (mvalid[d] && rdy) begin
          mvalid[d] = 0;
        end
      end
    end
  end

  // Monitor: compares what each DUT presents against the queue head and
  // retires the head when the consumer accepts it.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (q[d].size() > 0) begin
          chk($sformatf("d%0d_valid", d), int'(ov[d]), 1);
          chk($sformatf("d%0d_idx", d), int'(oi[d]), int'(q[d][0].idx));
          chk($sformatf("d%0d_onehot", d), int'(oo[d]), int'(q[d][0].oh));
          chk($sformatf("d%0d_multi", d), int'(om[d]), int'(q[d][0].m));
          if (rdy) void'(q[d].pop_front());
        end else begin
          chk($sformatf("d%0d_idle_valid", d), int'(ov[d]), 0);
          if (fresh[d]) begin
            chk($sformatf("d%0d_rst_idx", d), int'(oi[d]), 0);
            chk($sformatf("d%0d_rst_onehot", d), int'(oo[d]), 0);
            chk($sformatf("d%0d_rst_multi", d), int'(om[d]), 0);
          end
        end
      end
    end
  end

  task automatic drive(input logic e, input logic [4:0] r, input logic y);
    en  = e;
    req = r;
    rdy = y;
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid_fix4", int'(ov0), 0);
    chk("rst_valid_rr4", int'(ov1), 0);
    chk("rst_valid_rr5", int'(ov2), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;

    repeat (3) drive(1'b0, 5'b01111, 1'b1);

    drive(1'b1, 5'b00001, 1'b1);
    drive(1'b1, 5'b00010, 1'b1);
    drive(1'b1, 5'b00100, 1'b1);
    drive(1'b1, 5'b01000, 1'b1);
    drive(1'b1, 5'b00111, 1'b1);
    drive(1'b1, 5'b00000, 1'b1);

    drive(1'b1, 5'b00010, 1'b1);
    repeat (4) drive(1'b1, 5'b01000, 1'b0);
    drive(1'b1, 5'b01000, 1'b1);
    drive(1'b1, 5'b00000, 1'b1);
    drive(1'b1, 5'b00000, 1'b1);

    pulse_reset();
    repeat (5) drive(1'b1, 5'b01011, 1'b1);
    drive(1'b0, 5'b00000, 1'b1);

    pulse_reset();
    repeat (4) drive(1'b1, 5'b10001, 1'b1);
    drive(1'b0, 5'b00000, 1'b1);

    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(3, 0) != 0,
            ($urandom_range(7, 0) == 0) ? 5'b0 : 5'($urandom),
            $urandom_range(9, 0) < 7);
    end
    drive(1'b0, 5'b00000, 1'b1);
    drive(1'b0, 5'b00000, 1'b1);

    pulse_reset();
    drive(1'b1, 5'b00010, 1'b1);
    drive(1'b1, 5'b00101, 1'b0);
    pulse_reset();
    drive(1'b1, 5'b00101, 1'b1);
    chk("post_rst_rr4_valid", int'(ov1), 1);
    chk("post_rst_rr4_idx", int'(oi1), 0);
    drive(1'b0, 5'b00000, 1'b1);
    drive(1'b0, 5'b00000, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
